// File: rtl/alu_ctrl_arbiter_if.sv
// rtl/alu_ctrl_arbiter_if.sv - request/response/unit bus of the two-requester ALU arbiter
// Ports: none (signal bundle only).
//   master modport: requesters, response consumer and ALU units (drive req*, rsp_ready, unit_*).
//   slave modport : the arbiter (drives req*_ready, alu_*, enables, unit_fun, rsp_*, busy).
interface alu_ctrl_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [3:0]            req0_fun;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [3:0]            req1_fun;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  arith_en;
  logic                  logic_en;
  logic                  cmp_en;
  logic                  shift_en;
  logic [1:0]            unit_fun;
  logic [DATA_WIDTH-1:0] unit_out;
  logic                  unit_flag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_flag;

  logic                  busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_fun,
    output req1_valid, req1_a, req1_b, req1_fun,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, arith_en, logic_en, cmp_en, shift_en, unit_fun,
    output unit_out, unit_flag,
    input  rsp_valid, rsp_id, rsp_data, rsp_flag,
    output rsp_ready,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun,
    input  req1_valid, req1_a, req1_b, req1_fun,
    output req0_ready, req1_ready,
    output alu_a, alu_b, arith_en, logic_en, cmp_en, shift_en, unit_fun,
    input  unit_out, unit_flag,
    output rsp_valid, rsp_id, rsp_data, rsp_flag,
    input  rsp_ready,
    output busy
  );
endinterface

// File: rtl/alu_ctrl_arbiter.sv
// rtl/alu_ctrl_arbiter.sv - round-robin arbiter issuing one op at a time to registered ALU units
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - alu_ctrl_arbiter_if.slave: two requesters (valid/ready, a, b, fun), ALU unit
//         drive (alu_a/alu_b, one-hot enables, unit_fun) and return (unit_out/unit_flag),
//         response channel (rsp_valid/ready, rsp_id/data/flag), busy.
module alu_ctrl_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  alu_ctrl_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic                  last_grant;
  logic                  op_id;

  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [1:0]            unit_fun_q;
  logic [3:0]            en_q;        // bit0 arith, bit1 logic, bit2 cmp, bit3 shift
  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_flag_q;

  logic                  grant_valid;
  logic                  grant_id;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [3:0]            sel_fun;

  // Grant is combinational and only offered in IDLE; it is masked while rst is high
  // so every output reads 0 during reset even if requesters hold valid.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign sel_a   = grant_id ? bus.req1_a   : bus.req0_a;
  assign sel_b   = grant_id ? bus.req1_b   : bus.req0_b;
  assign sel_fun = grant_id ? bus.req1_fun : bus.req0_fun;

  assign bus.req0_ready = grant_valid && !grant_id;
  assign bus.req1_ready = grant_valid &&  grant_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      op_id       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      unit_fun_q  <= 2'b00;
      en_q        <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            // The ISSUE-cycle drive registers double as the operand latch, so later
            // requester changes cannot reach the in-flight operation.
            op_id      <= grant_id;
            last_grant <= grant_id;
            alu_a_q    <= sel_a;
            alu_b_q    <= sel_b;
            unit_fun_q <= sel_fun[1:0];
            en_q       <= 4'b0001 << sel_fun[3:2];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          alu_a_q    <= '0;
          alu_b_q    <= '0;
          unit_fun_q <= 2'b00;
          en_q       <= 4'b0000;
          state      <= WAIT;
        end
        WAIT: begin
          // Units register their result at the end of ISSUE; it is visible here.
          rsp_data_q  <= bus.unit_out;
          rsp_flag_q  <= bus.unit_flag;
          rsp_id_q    <= op_id;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flag_q  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.unit_fun  = unit_fun_q;
  assign bus.arith_en  = en_q[0];
  assign bus.logic_en  = en_q[1];
  assign bus.cmp_en    = en_q[2];
  assign bus.shift_en  = en_q[3];
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flag  = rsp_flag_q;
  assign bus.busy      = (state != IDLE);

endmodule
